// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754-style adder/subtractor: S1 unpack/compare/align, S2 add/normalise, S3 round/pack.
// Handshake: a beat moves on an edge with valid && ready; every stage advances together when adv = !out_valid || out_ready.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int FW  = MAN_W + 4;  // hidden, fraction, guard, round, sticky
  localparam int XW  = EXP_W + 2;
  localparam int LZW = $clog2(FW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic          valid;
    logic          sign;
    logic          eff_sub;
    logic [XW-1:0] exp;
    logic [FW-1:0] man_l;
    logic [FW-1:0] man_s;
    logic          spec;
    logic [W-1:0]  spec_res;
    logic [3:0]    spec_flg;
  } s1_t;

  typedef struct packed {
    logic          valid;
    logic          sign;
    logic [XW-1:0] exp;
    logic [FW-1:0] man;
    logic          spec;
    logic [W-1:0]  spec_res;
    logic [3:0]    spec_flg;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic         out_valid_d, out_valid_q;
  logic [W-1:0] result_d, result_q;
  logic [3:0]   flags_d, flags_q;
  logic         adv;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  function automatic logic [LZW-1:0] lzc(input logic [FW-1:0] v);
    lzc = LZW'(FW);
    for (int i = 0; i < FW; i++) begin
      if (v[i]) lzc = LZW'(FW - 1 - i);
    end
  endfunction

  // Operand classification; b's sign is folded with sub to give its effective sign.
  logic           sa, sb, a_ge;
  logic           a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [XW-1:0]  xa, xb, dsh;
  logic [MAN_W:0] ma, mb;
  logic [FW-1:0]  ext_s, sh_s, lost_mask;

  assign sa     = a[W-1];
  assign sb     = b[W-1] ^ sub;
  assign a_ge   = a[W-2:0] >= b[W-2:0];
  assign a_inf  = (a[W-2:MAN_W] == EXP_ONES) && (a[MAN_W-1:0] == '0);
  assign b_inf  = (b[W-2:MAN_W] == EXP_ONES) && (b[MAN_W-1:0] == '0);
  assign a_nan  = (a[W-2:MAN_W] == EXP_ONES) && (a[MAN_W-1:0] != '0);
  assign b_nan  = (b[W-2:MAN_W] == EXP_ONES) && (b[MAN_W-1:0] != '0);
  assign a_snan = a_nan && !a[MAN_W-1];
  assign b_snan = b_nan && !b[MAN_W-1];
  assign xa     = (a[W-2:MAN_W] == '0) ? XW'(1) : {2'b00, a[W-2:MAN_W]};
  assign xb     = (b[W-2:MAN_W] == '0) ? XW'(1) : {2'b00, b[W-2:MAN_W]};
  assign ma     = {(a[W-2:MAN_W] != '0), a[MAN_W-1:0]};
  assign mb     = {(b[W-2:MAN_W] != '0), b[MAN_W-1:0]};

  always_comb begin
    s1_d         = '0;
    s1_d.valid   = in_valid;
    s1_d.sign    = a_ge ? sa : sb;
    s1_d.eff_sub = sa ^ sb;
    s1_d.exp     = a_ge ? xa : xb;
    s1_d.man_l   = {(a_ge ? ma : mb), 3'b000};
    ext_s        = {(a_ge ? mb : ma), 3'b000};
    dsh          = a_ge ? (xa - xb) : (xb - xa);
    sh_s         = ext_s >> dsh;
    lost_mask    = ~({FW{1'b1}} << dsh);
    s1_d.man_s   = {sh_s[FW-1:1], sh_s[0] | (|(ext_s & lost_mask))};
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = QNAN;
      s1_d.spec_flg = {a_snan || b_snan || (a_inf && b_inf), 3'b000};
    end else if (a_inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  logic [FW:0]   sum;
  logic [XW-1:0] lz, lim, nsh;

  always_comb begin
    s2_d          = '0;
    s2_d.valid    = s1_q.valid;
    s2_d.spec     = s1_q.spec;
    s2_d.spec_res = s1_q.spec_res;
    s2_d.spec_flg = s1_q.spec_flg;
    sum = s1_q.eff_sub ? ({1'b0, s1_q.man_l} - {1'b0, s1_q.man_s})
                       : ({1'b0, s1_q.man_l} + {1'b0, s1_q.man_s});
    lz  = XW'(lzc(sum[FW-1:0]));
    lim = s1_q.exp - XW'(1);
    nsh = (lz < lim) ? lz : lim;
    if (sum[FW]) begin
      s2_d.man = {sum[FW:2], sum[1] | sum[0]};
      s2_d.exp = s1_q.exp + XW'(1);
    end else begin
      // Left shift stops at exponent 1; a clear hidden bit then means subnormal.
      s2_d.man = sum[FW-1:0] << nsh;
      s2_d.exp = s1_q.exp - nsh;
    end
    s2_d.sign = ((sum == '0) && s1_q.eff_sub) ? 1'b0 : s1_q.sign;
  end

  logic             inexact, round_up;
  logic [MAN_W+1:0] manr;
  logic [XW-1:0]    exp3;

  always_comb begin
    inexact     = |s2_q.man[2:0];
    round_up    = s2_q.man[2] && (s2_q.man[1] || s2_q.man[0] || s2_q.man[3]);
    manr        = {1'b0, s2_q.man[FW-1:3]} + (MAN_W+2)'(round_up);
    exp3        = s2_q.exp;
    if (manr[MAN_W+1]) begin
      manr = manr >> 1;
      exp3 = exp3 + XW'(1);
    end
    out_valid_d = s2_q.valid;
    if (s2_q.spec) begin
      result_d = s2_q.spec_res;
      flags_d  = s2_q.spec_flg;
    end else if (exp3 >= {2'b00, EXP_ONES}) begin
      result_d = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
      flags_d  = 4'b0101;
    end else begin
      result_d = {s2_q.sign, (manr[MAN_W] ? exp3[EXP_W-1:0] : {EXP_W{1'b0}}), manr[MAN_W-1:0]};
      flags_d  = {2'b00, !manr[MAN_W] && inexact, inexact};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe: hand-computed results, in-order scoreboard,
// latency, stall-hold and reset-flush checks.
module tb_fp_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t        vecs [22];
  logic [35:0] exp_q [$];
  int          acc_q [$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          stray;
  bit          lat_chk = 1'b0;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] va, input logic [31:0] vb,
                         input logic vs, input logic [31:0] vr, input logic [3:0] vf);
    vecs[i] = {va, vb, vs, vr, vf};
  endtask

  // Driver: drives at negedge, looks at in_ready 1 ns later, beat taken on the next posedge.
  task automatic send(input int idx);
    int budget = 0;
    in_valid = 1'b1;
    a        = vecs[idx].a;
    b        = vecs[idx].b;
    sub      = vecs[idx].sub;
    #1;
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
    else begin
      exp_q.push_back({vecs[idx].f, vecs[idx].r});
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // Scoreboard
  always @(negedge clk) begin
    logic [35:0] e;
    int          acc;
    #2;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) check_eq("unexpected_out", 64'(exp_q.size()), 64'd1);
      else if (out_ready) begin
        e   = exp_q.pop_front();
        acc = acc_q.pop_front();
        check_eq("result", 64'(result), 64'(e[31:0]));
        check_eq("flags", 64'(flags), 64'(e[35:32]));
        if (lat_chk) check_eq("latency", 64'(cyc - acc), 64'd3);
      end else begin
        check_eq("hold", 64'({flags, result}), 64'(exp_q[0]));
      end
    end
  end

  initial begin
    set_vec(0,  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);
    set_vec(1,  32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1);
    set_vec(2,  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1);
    set_vec(3,  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5);
    set_vec(4,  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8);
    set_vec(5,  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0);
    set_vec(6,  32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'h0);
    set_vec(7,  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0);
    set_vec(8,  32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0);
    set_vec(9,  32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'h8);
    set_vec(10, 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'h0);
    set_vec(11, 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0);
    set_vec(12, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0);
    set_vec(13, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0);
    set_vec(14, 32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 4'h0);
    set_vec(15, 32'h007FFFFF, 32'h00000001, 1'b0, 32'h00800000, 4'h0);
    set_vec(16, 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1);
    set_vec(17, 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'h0);
    set_vec(18, 32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'h5);
    set_vec(19, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'h0);
    set_vec(20, 32'hFF800000, 32'h7F800000, 1'b0, 32'h7FC00000, 4'h8);
    set_vec(21, 32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'h0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_flags", 64'(flags), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_eq("ready_after_rst", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed vectors, back-to-back, no backpressure
    lat_chk = 1'b1;
    for (int i = 0; i < 22; i++) send(i);
    wait_drain();
    lat_chk = 1'b0;

    // Ten-beat stream with out_ready low for cycles 5-8
    fork
      begin
        for (int i = 0; i < 10; i++) send(i);
      end
      begin
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          out_ready = !(k >= 5 && k <= 8);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Three beats in flight, then a one-cycle reset
    out_ready = 1'b0;
    send(3);
    send(4);
    send(5);
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #3;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_result", 64'(result), 64'd0);
    check_eq("midrst_flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      #3;
      if (out_valid) stray++;
    end
    check_eq("no_stale", 64'(stray), 64'd0);
    @(negedge clk);
    send(12);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
